// File: rtl/usb_acia_pkg.sv
// rtl/usb_acia_pkg.sv - register offsets, bit indices and helpers for the USB ACIA FIFO block
package usb_acia_pkg;

    localparam logic [1:0] REG_STAT       = 2'd0;
    localparam logic [1:0] REG_CTRL       = 2'd0;
    localparam logic [1:0] REG_DATA       = 2'd1;
    localparam logic [1:0] REG_RXCNT      = 2'd2;
    localparam logic [1:0] REG_TXFREE_THR = 2'd3;

    localparam int ST_RX_NOT_EMPTY = 0;
    localparam int ST_TX_NOT_FULL  = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_RX_UNF       = 3;
    localparam int ST_TX_OVF       = 4;
    localparam int ST_LPBK         = 5;
    localparam int ST_IRQ          = 7;

    localparam int CT_FLUSH = 0;
    localparam int CT_CLR   = 1;
    localparam int CT_LPBK  = 2;
    localparam int CT_TIE   = 6;
    localparam int CT_RIE   = 7;

    // Counts reach 256 only at the largest depth; clamp to the 8-bit read path.
    function automatic logic [7:0] sat8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/usb_acia_fifo_fifo.sv
// rtl/usb_acia_fifo_fifo.sv - acia_sync_fifo: power-of-two synchronous FIFO with flush and occupancy count
module acia_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [W-1:0]       din,
    output logic [W-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    // Push is judged on the pre-pop count, so a full FIFO never accepts.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/usb_acia_fifo.sv
// rtl/usb_acia_fifo.sv - buffered USB ACIA: CPU register bus to MUACM byte streams
// Optional internal TX->RX loopback with USB_ACIA_LOOPBACK_EN.
module usb_acia_fifo
    import usb_acia_pkg::*;
#(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] rx_data,
    input  logic       rx_val,
    output logic       rx_rdy,
    output logic [7:0] tx_data,
    output logic       tx_val,
    input  logic       tx_rdy,
    output logic       irq
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);

    logic rd_stb, wr_stb, ctrl_wr, data_rd, data_wr, flush, clr_flags;
    logic [7:0] rx_head, tx_head, rx_din, status;
    logic [RX_AW:0] rx_count;
    logic [TX_AW:0] tx_count, tx_free;
    logic rx_full, rx_empty, tx_full, tx_empty;
    logic rx_push, rx_pop, tx_pop, lpbk_bit;

    logic       rie_q, rie_d, tie_q, tie_d, irq_q, irq_d;
    logic       rx_unf_q, rx_unf_d, tx_ovf_q, tx_ovf_d;
    logic [7:0] thresh_q, thresh_d, dout_q, dout_d;

    assign rd_stb    = cs & ~we;
    assign wr_stb    = cs & we;
    assign ctrl_wr   = wr_stb && (rs == REG_CTRL);
    assign data_rd   = rd_stb && (rs == REG_DATA);
    assign data_wr   = wr_stb && (rs == REG_DATA);
    assign flush     = ctrl_wr & din[CT_FLUSH];
    assign clr_flags = ctrl_wr & din[CT_CLR];
    assign rx_pop    = data_rd & ~rx_empty;

`ifdef USB_ACIA_LOOPBACK_EN
    logic lpbk_q, move;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       lpbk_q <= 1'b0;
        else if (ctrl_wr) lpbk_q <= din[CT_LPBK];
    end

    // Streams are stalled, not dropped, while the internal path owns the FIFOs.
    assign move     = lpbk_q & ~tx_empty & ~rx_full;
    assign rx_rdy   = ~rx_full & ~lpbk_q;
    assign tx_val   = ~tx_empty & ~lpbk_q;
    assign rx_push  = move | (rx_val & rx_rdy);
    assign rx_din   = lpbk_q ? tx_head : rx_data;
    assign tx_pop   = move | (tx_val & tx_rdy);
    assign lpbk_bit = lpbk_q;
`else
    assign rx_rdy   = ~rx_full;
    assign tx_val   = ~tx_empty;
    assign rx_push  = rx_val & rx_rdy;
    assign rx_din   = rx_data;
    assign tx_pop   = tx_val & tx_rdy;
    assign lpbk_bit = 1'b0;
`endif

    acia_sync_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .flush(flush),
        .din(rx_din), .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    acia_sync_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(data_wr), .pop(tx_pop), .flush(flush),
        .din(din), .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    assign tx_free = (TX_AW+1)'(TX_DEPTH) - tx_count;

    always_comb begin
        status                  = '0;
        status[ST_RX_NOT_EMPTY] = ~rx_empty;
        status[ST_TX_NOT_FULL]  = ~tx_full;
        status[ST_TX_EMPTY]     = tx_empty;
        status[ST_RX_UNF]       = rx_unf_q;
        status[ST_TX_OVF]       = tx_ovf_q;
        status[ST_LPBK]         = lpbk_bit;
        status[ST_IRQ]          = irq_q;

        rie_d    = rie_q;
        tie_d    = tie_q;
        thresh_d = thresh_q;
        if (ctrl_wr) begin
            rie_d = din[CT_RIE];
            tie_d = din[CT_TIE];
        end
        if (wr_stb && rs == REG_TXFREE_THR) begin
            thresh_d = (din == 8'd0) ? 8'd1 : din;
        end

        rx_unf_d = clr_flags ? 1'b0 : (rx_unf_q | (data_rd & rx_empty));
        tx_ovf_d = clr_flags ? 1'b0 : (tx_ovf_q | (data_wr & tx_full));

        irq_d = (rie_q && (9'(rx_count) >= {1'b0, thresh_q})) | (tie_q & tx_empty);

        dout_d = dout_q;
        if (rd_stb) begin
            case (rs)
                REG_STAT:  dout_d = status;
                REG_DATA:  dout_d = rx_empty ? 8'h00 : rx_head;
                REG_RXCNT: dout_d = sat8(9'(rx_count));
                default:   dout_d = sat8(9'(tx_free));
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rie_q    <= 1'b0;
            tie_q    <= 1'b0;
            thresh_q <= 8'd1;
            rx_unf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            irq_q    <= 1'b0;
            dout_q   <= 8'h00;
        end else begin
            rie_q    <= rie_d;
            tie_q    <= tie_d;
            thresh_q <= thresh_d;
            rx_unf_q <= rx_unf_d;
            tx_ovf_q <= tx_ovf_d;
            irq_q    <= irq_d;
            dout_q   <= dout_d;
        end
    end

    assign dout    = dout_q;
    assign irq     = irq_q;
    assign tx_data = tx_head;

endmodule
